// File: rtl/barrier_opl_pkg.sv
// Shared definitions for the barrier output-port-lookup stage: FSM
// encodings, mask widths, IOQ header field positions and the debug view
// of the barrier tracker.
package barrier_opl_pkg;

  // Packet framing FSM: module headers vs. packet body.
  typedef enum logic {
    IN_MODULE_HDRS = 1'b0,
    IN_PACKET      = 1'b1
  } pkt_state_e;

  // Barrier FSM: nothing pending vs. collecting arrivals.
  typedef enum logic {
    IDLE   = 1'b0,
    GATHER = 1'b1
  } barrier_state_e;

  // One-hot destination port field of the IOQ header.
  localparam int PORT_MASK_W = 16;
  // Width of the participant configuration mask.
  localparam int PART_MASK_W = 8;

  // Header field positions and register ring widths.
  localparam int IOQ_DST_POS   = 0;
  localparam int IOQ_SRC_POS   = 16;
  localparam int IOQ_STAGE_NUM = 8'hff;
  localparam int REG_ADDR_W    = 23;
  localparam int REG_DATA_W    = 32;

  // Snapshot of the barrier tracker for probing.
  typedef struct packed {
    barrier_state_e          state;
    logic                    cpu_arrived;
    logic [PART_MASK_W-1:0]  arrived;
  } barrier_dbg_t;

endpackage

// File: rtl/barrier_output_port_lookup_tracker.sv
// Barrier tracker: records MAC and CPU arrivals, decides the destination
// mask of each IOQ header and detects completion. With BARRIER_TIMEOUT_EN
// defined, a stalled barrier is aborted after TIMEOUT_CYCLES idle cycles.
module barrier_tracker
    import barrier_opl_pkg::*;
#(
    parameter int                     NUM_OUTPUT_QUEUES = 8,
    parameter int                     CPU_QUEUE_NUM     = 0,
    parameter logic [PART_MASK_W-1:0] PARTICIPANT_MASK  = 8'h0F,
    parameter logic [PORT_MASK_W-1:0] ANNOUNCE_MASK     = 16'h0055,
    parameter logic [PORT_MASK_W-1:0] RELEASE_MASK      = 16'h0002,
    parameter int                     TIMEOUT_CYCLES    = 1_000_000
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_hdr_valid,
    input  logic [15:0]            i_src,
    input  logic                   i_is_cpu,
    output logic [PORT_MASK_W-1:0] o_dst,
    output logic                   o_timeout,
    output barrier_dbg_t           o_dbg
);
    localparam int               NPART    = NUM_OUTPUT_QUEUES / 2;
    localparam logic [NPART-1:0] PMASK    = NPART'(PARTICIPANT_MASK);
    localparam logic [15:0]      CPU_PORT = 16'(2 * CPU_QUEUE_NUM + 1);

    barrier_state_e   r_state, w_state_nxt;
    logic [NPART-1:0] r_arrived, w_arrived_nxt;
    logic             r_cpu_arrived, w_cpu_nxt;
    logic [NPART-1:0] w_pbit;
    logic             w_accept;
    logic             w_complete;
    logic             w_expire;

    // One-hot participant bit; an index beyond the MAC range shifts out to 0.
    assign w_pbit = NPART'(1) << i_src[15:1];

    // Arrival decode: destination mask and next tracking state.
    always_comb begin
        w_state_nxt   = r_state;
        w_arrived_nxt = r_arrived;
        w_cpu_nxt     = r_cpu_arrived;
        o_dst         = '0;
        w_accept      = 1'b0;
        w_complete    = 1'b0;
        if (i_hdr_valid) begin
            if (i_is_cpu) begin
                if ((i_src == CPU_PORT) && !r_cpu_arrived) begin
                    w_accept = 1'b1;
                    if ((r_arrived & PMASK) == PMASK) begin
                        o_dst      = ANNOUNCE_MASK | RELEASE_MASK;
                        w_complete = 1'b1;
                    end else begin
                        o_dst       = ANNOUNCE_MASK;
                        w_cpu_nxt   = 1'b1;
                        w_state_nxt = GATHER;
                    end
                end
            end else if (((w_pbit & PMASK) != '0) && ((w_pbit & r_arrived) == '0)) begin
                w_accept = 1'b1;
                if ((((r_arrived | w_pbit) & PMASK) == PMASK) && r_cpu_arrived) begin
                    o_dst      = RELEASE_MASK;
                    w_complete = 1'b1;
                end else begin
                    w_arrived_nxt = r_arrived | w_pbit;
                    w_state_nxt   = GATHER;
                end
            end
        end
        if (w_complete) begin
            w_arrived_nxt = '0;
            w_cpu_nxt     = 1'b0;
            w_state_nxt   = IDLE;
        end
    end

    // Tracking registers; an expiry (never coincident with an arrival) clears them.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_arrived     <= '0;
            r_cpu_arrived <= 1'b0;
        end else if (w_expire) begin
            r_state       <= IDLE;
            r_arrived     <= '0;
            r_cpu_arrived <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_arrived     <= w_arrived_nxt;
            r_cpu_arrived <= w_cpu_nxt;
        end
    end

`ifdef BARRIER_TIMEOUT_EN
    logic [31:0] r_cnt;
    logic        r_timeout;

    // Any accepted arrival (including the completing one) beats expiry.
    assign w_expire  = (r_state == GATHER) && !w_accept &&
                       (r_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign o_timeout = r_timeout;

    // Idle-cycle counter while gathering, plus the sticky abort flag.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state == GATHER) && !w_accept && !w_expire) r_cnt <= r_cnt + 32'd1;
            else                                               r_cnt <= '0;
            if (w_expire) r_timeout <= 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_expire         = 1'b0;
    assign o_timeout        = 1'b0;
    assign w_unused_timeout = ^{w_accept, 32'(TIMEOUT_CYCLES)};
`endif

    assign o_dbg.state       = r_state;
    assign o_dbg.cpu_arrived = r_cpu_arrived;
    assign o_dbg.arrived     = PART_MASK_W'(r_arrived);
endmodule

// File: rtl/small_fifo.sv
// Small synchronous FIFO with a registered read port: dout is loaded on
// the edge where rd_en is accepted. nearly_full flags one free slot left.
module small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_wr_en,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_nearly_full,
    output logic             o_empty
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          r_mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
    logic [MAX_DEPTH_BITS:0]   r_count;
    logic                      w_do_wr;
    logic                      w_do_rd;

    // Writes into a full FIFO are ignored so the storage is never corrupted.
    assign w_do_wr       = i_wr_en && (r_count != (MAX_DEPTH_BITS+1)'(DEPTH));
    assign w_do_rd       = i_rd_en && (r_count != '0);
    assign o_empty       = (r_count == '0);
    assign o_nearly_full = (r_count >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_din;
    end

    // Pointers, occupancy and registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            o_dout   <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + MAX_DEPTH_BITS'(1);
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + MAX_DEPTH_BITS'(1);
                o_dout   <= r_mem[r_rd_ptr];
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (MAX_DEPTH_BITS+1)'(1);
                2'b01:   r_count <= r_count - (MAX_DEPTH_BITS+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/barrier_output_port_lookup.sv
// Barrier output-port-lookup stage: buffers packets in a small FIFO and
// rewrites the IOQ header destination mask from the barrier tracker.
// Optional build macro: BARRIER_TIMEOUT_EN (timeout abort of a stalled barrier).
module barrier_output_port_lookup
    import barrier_opl_pkg::*;
#(
    parameter int                     DATA_WIDTH         = 64,
    parameter int                     CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter int                     UDP_REG_SRC_WIDTH  = 2,
    parameter int                     IO_QUEUE_STAGE_NUM = IOQ_STAGE_NUM,
    parameter int                     NUM_OUTPUT_QUEUES  = 8,
    parameter int                     CPU_QUEUE_NUM      = 0,
    parameter logic [PART_MASK_W-1:0] PARTICIPANT_MASK   = 8'h0F,
    parameter logic [PORT_MASK_W-1:0] ANNOUNCE_MASK      = 16'h0055,
    parameter logic [PORT_MASK_W-1:0] RELEASE_MASK       = 16'h0002,
    parameter int                     FIFO_DEPTH_BITS    = 2,
    parameter int                     TIMEOUT_CYCLES     = 1_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [CTRL_WIDTH-1:0]        in_ctrl,
    input  logic                         in_wr,
    output logic                         in_rdy,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CTRL_WIDTH-1:0]        out_ctrl,
    output logic                         out_wr,
    input  logic                         out_rdy,
    input  logic                         reg_req_in,
    input  logic                         reg_ack_in,
    input  logic                         reg_rd_wr_L_in,
    input  logic [REG_ADDR_W-1:0]        reg_addr_in,
    input  logic [REG_DATA_W-1:0]        reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,
    output logic                         reg_req_out,
    output logic                         reg_ack_out,
    output logic                         reg_rd_wr_L_out,
    output logic [REG_ADDR_W-1:0]        reg_addr_out,
    output logic [REG_DATA_W-1:0]        reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,
    output logic                         barrier_timeout
);
    pkt_state_e                      r_pkt_state, w_pkt_state_nxt;
    logic                            w_hdr_valid;
    logic [15:0]                     w_src;
    logic [PORT_MASK_W-1:0]          w_dst;
    logic [DATA_WIDTH-1:0]           w_fifo_data;
    logic [CTRL_WIDTH+DATA_WIDTH-1:0] w_fifo_dout;
    logic                            w_fifo_nearly_full;
    logic                            w_fifo_empty;
    logic                            w_fifo_rd_en;
    logic                            r_out_wr;
    barrier_dbg_t                    w_trk_dbg;
    logic                            w_unused_dbg;

    // Only the IOQ header word of the module-header section is rewritten.
    assign w_hdr_valid = in_wr && (r_pkt_state == IN_MODULE_HDRS) &&
                         (in_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM));
    assign w_src       = in_data[IOQ_SRC_POS +: 16];

    // Packet framing state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_pkt_state <= IN_MODULE_HDRS;
        else        r_pkt_state <= w_pkt_state_nxt;
    end

    // Framing transitions: ctrl==0 starts the body, ctrl!=0 ends it.
    always_comb begin
        w_pkt_state_nxt = r_pkt_state;
        case (r_pkt_state)
            IN_MODULE_HDRS: if (in_wr && (in_ctrl == '0)) w_pkt_state_nxt = IN_PACKET;
            IN_PACKET:      if (in_wr && (in_ctrl != '0)) w_pkt_state_nxt = IN_MODULE_HDRS;
            default:        w_pkt_state_nxt = IN_MODULE_HDRS;
        endcase
    end

    barrier_tracker #(
        .NUM_OUTPUT_QUEUES (NUM_OUTPUT_QUEUES),
        .CPU_QUEUE_NUM     (CPU_QUEUE_NUM),
        .PARTICIPANT_MASK  (PARTICIPANT_MASK),
        .ANNOUNCE_MASK     (ANNOUNCE_MASK),
        .RELEASE_MASK      (RELEASE_MASK),
        .TIMEOUT_CYCLES    (TIMEOUT_CYCLES)
    ) u_tracker (
        .clk         (clk),
        .i_rst_n     (reset),
        .i_hdr_valid (w_hdr_valid),
        .i_src       (w_src),
        .i_is_cpu    (w_src[0]),
        .o_dst       (w_dst),
        .o_timeout   (barrier_timeout),
        .o_dbg       (w_trk_dbg)
    );

    // Tracker snapshot is kept for probing only.
    assign w_unused_dbg = ^w_trk_dbg;

    // Splice the computed destination mask into the header word.
    always_comb begin
        w_fifo_data = in_data;
        if (w_hdr_valid) w_fifo_data[IOQ_DST_POS +: PORT_MASK_W] = w_dst;
    end

    small_fifo #(
        .WIDTH          (CTRL_WIDTH + DATA_WIDTH),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (reset),
        .i_din         ({in_ctrl, w_fifo_data}),
        .i_wr_en       (in_wr),
        .i_rd_en       (w_fifo_rd_en),
        .o_dout        (w_fifo_dout),
        .o_nearly_full (w_fifo_nearly_full),
        .o_empty       (w_fifo_empty)
    );

    // Handshake: upstream may write while in_rdy is high; a word is
    // presented downstream for exactly one cycle with out_wr high, one
    // cycle after the read was issued while out_rdy was high.
    assign in_rdy       = !w_fifo_nearly_full;
    assign w_fifo_rd_en = out_rdy && !w_fifo_empty;
    assign out_wr       = r_out_wr;
    assign {out_ctrl, out_data} = w_fifo_dout;

    // Output strobe follows the FIFO read by one cycle, matching dout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_out_wr <= 1'b0;
        else        r_out_wr <= w_fifo_rd_en;
    end

    // Register ring: plain one-cycle pass-through, this stage owns no registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_req_out     <= 1'b0;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b0;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;
        end else begin
            reg_req_out     <= reg_req_in;
            reg_ack_out     <= reg_ack_in;
            reg_rd_wr_L_out <= reg_rd_wr_L_in;
            reg_addr_out    <= reg_addr_in;
            reg_data_out    <= reg_data_in;
            reg_src_out     <= reg_src_in;
        end
    end
endmodule

// File: tb/tb_barrier_output_port_lookup.sv
// Directed bench for barrier_output_port_lookup (default parameters,
// TIMEOUT_CYCLES=100). Honours BARRIER_TIMEOUT_EN if defined at build.
module tb_barrier_output_port_lookup;
    import barrier_opl_pkg::*;

`ifdef BARRIER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [63:0] BODY_W = 64'h0123_4567_89ab_cdef;
    localparam logic [63:0] LAST_W = 64'hfeed_face_0000_1111;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [63:0]           in_data;
    logic [7:0]            in_ctrl;
    logic                  in_wr;
    logic                  in_rdy;
    logic [63:0]           out_data;
    logic [7:0]            out_ctrl;
    logic                  out_wr;
    logic                  out_rdy;
    logic                  reg_req_in, reg_ack_in, reg_rd_wr_L_in;
    logic [REG_ADDR_W-1:0] reg_addr_in;
    logic [REG_DATA_W-1:0] reg_data_in;
    logic [1:0]            reg_src_in;
    logic                  reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [REG_ADDR_W-1:0] reg_addr_out;
    logic [REG_DATA_W-1:0] reg_data_out;
    logic [1:0]            reg_src_out;
    logic                  barrier_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    logic [71:0] got_q[$];

    barrier_output_port_lookup #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
        .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
        .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
        .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
        .barrier_timeout(barrier_timeout)
    );

    // Clock
    always #5 clk = ~clk;

    // Output monitor: every word presented downstream, in order.
    always @(negedge clk) begin
        if (out_wr) got_q.push_back({out_ctrl, out_data});
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1);
    end

    function automatic logic [63:0] hdr_in(input logic [15:0] src);
        return {16'd24, 16'd3, src, 16'habcd};
    endfunction

    function automatic logic [71:0] exp_hdr(input logic [15:0] src, input logic [15:0] dst);
        return {8'hff, 16'd24, 16'd3, src, dst};
    endfunction

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_pkt(input logic [15:0] src);
        @(negedge clk); in_wr = 1'b1; in_ctrl = 8'hff; in_data = hdr_in(src);
        @(negedge clk); in_ctrl = 8'h00; in_data = BODY_W;
        @(negedge clk); in_ctrl = 8'h80; in_data = LAST_W;
        @(negedge clk); in_wr = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int n);
        int k = 0;
        while (got_q.size() < n && k < 100) begin
            @(posedge clk);
            k++;
        end
        n_cmp++;
        assert (got_q.size() >= n) else begin
            n_bad++;
            $error("FAIL %s/timeout: observed %0d words expected %0d", tag, got_q.size(), n);
        end
    endtask

    task automatic expect_pkt(input string tag, input logic [15:0] src, input logic [15:0] dst);
        wait_words(tag, 3);
        if (got_q.size() >= 3) begin
            check({tag, "/hdr"},  got_q.pop_front(), exp_hdr(src, dst));
            check({tag, "/body"}, got_q.pop_front(), {8'h00, BODY_W});
            check({tag, "/last"}, got_q.pop_front(), {8'h80, LAST_W});
        end
    endtask

    task automatic pkt(input string tag, input logic [15:0] src, input logic [15:0] dst);
        send_pkt(src);
        expect_pkt(tag, src, dst);
    endtask

    task automatic check_trk(input string tag, input barrier_state_e st, input logic cpu, input logic [7:0] arr);
        check({tag, "/state"}, 72'(dut.w_trk_dbg.state), 72'(st));
        check({tag, "/cpu"},   72'(dut.w_trk_dbg.cpu_arrived), 72'(cpu));
        check({tag, "/arr"},   72'(dut.w_trk_dbg.arrived), 72'(arr));
    endtask

    initial begin
        reset = 1'b0; in_wr = 1'b0; in_ctrl = '0; in_data = '0; out_rdy = 1'b1;
        reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
        reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst/out_wr", 72'(out_wr), 72'(0));
        check("rst/in_rdy", 72'(in_rdy), 72'(1));
        check("rst/timeout", 72'(barrier_timeout), 72'(0));
        check("rst/reg_out", 72'({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out}), 72'(0));
        check_trk("rst", IDLE, 1'b0, 8'h00);
        reset = 1'b1;

        // Register ring pass-through, both directions of every bit
        @(negedge clk);
        reg_req_in = 1'b1; reg_ack_in = 1'b1; reg_rd_wr_L_in = 1'b1;
        reg_addr_in = 23'h5a5a5; reg_data_in = 32'hdeadbeef; reg_src_in = 2'b10;
        @(negedge clk);
        check("reg/set", 72'({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out}),
              72'({1'b1, 1'b1, 1'b1, 23'h5a5a5, 32'hdeadbeef, 2'b10}));
        reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
        reg_addr_in = 23'h2a5a; reg_data_in = 32'h1234_5678; reg_src_in = 2'b01;
        @(negedge clk);
        check("reg/chg", 72'({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out}),
              72'({1'b0, 1'b0, 1'b0, 23'h2a5a, 32'h1234_5678, 2'b01}));

        // CPU first, MACs after
        pkt("t1/cpu0", 16'd1, 16'h0055);
        check_trk("t1/after_cpu", GATHER, 1'b1, 8'h00);
        pkt("t1/mac0", 16'd0, 16'h0000);
        pkt("t1/mac1", 16'd2, 16'h0000);
        pkt("t1/mac2", 16'd4, 16'h0000);
        pkt("t1/mac3", 16'd6, 16'h0002);
        check_trk("t1/done", IDLE, 1'b0, 8'h00);

        // MACs first, CPU last
        pkt("t2/mac0", 16'd0, 16'h0000);
        pkt("t2/mac1", 16'd2, 16'h0000);
        pkt("t2/mac2", 16'd4, 16'h0000);
        pkt("t2/mac3", 16'd6, 16'h0000);
        check_trk("t2/all_mac", GATHER, 1'b0, 8'h0f);
        pkt("t2/cpu0", 16'd1, 16'h0057);
        check_trk("t2/done", IDLE, 1'b0, 8'h00);

        // Duplicates and foreign ports
        pkt("t3/cpu0", 16'd1, 16'h0055);
        pkt("t3/mac1", 16'd2, 16'h0000);
        pkt("t3/mac1_dup", 16'd2, 16'h0000);
        pkt("t3/mac5", 16'd10, 16'h0000);
        pkt("t3/cpu1", 16'd3, 16'h0000);
        pkt("t3/cpu0_dup", 16'd1, 16'h0000);
        check_trk("t3/partial", GATHER, 1'b1, 8'h02);
        pkt("t3/mac0", 16'd0, 16'h0000);
        pkt("t3/mac2", 16'd4, 16'h0000);
        pkt("t3/mac3", 16'd6, 16'h0002);
        check_trk("t3/done", IDLE, 1'b0, 8'h00);

        // Latency with out_rdy high: out_wr rises two cycles after input
        @(negedge clk); in_wr = 1'b1; in_ctrl = 8'hff; in_data = hdr_in(16'd10);
        @(negedge clk); in_ctrl = 8'h00; in_data = BODY_W;
        check("lat/cyc1", 72'(out_wr), 72'(0));
        @(negedge clk); in_ctrl = 8'h80; in_data = LAST_W;
        check("lat/cyc2", 72'(out_wr), 72'(1));
        check("lat/word", {out_ctrl, out_data}, exp_hdr(16'd10, 16'h0000));
        @(negedge clk); in_wr = 1'b0;
        expect_pkt("lat", 16'd10, 16'h0000);

        // Backpressure: fill to nearly_full, then drain with out_rdy 1-0-1
        @(negedge clk); out_rdy = 1'b0;
        in_wr = 1'b1; in_ctrl = 8'hff; in_data = hdr_in(16'd10);
        @(negedge clk); in_ctrl = 8'h00; in_data = BODY_W;
        @(negedge clk); in_ctrl = 8'h80; in_data = LAST_W;
        check("bp/rdy_at2", 72'(in_rdy), 72'(1));
        @(negedge clk); in_wr = 1'b0;
        check("bp/rdy_at3", 72'(in_rdy), 72'(0));
        check("bp/held", 72'(got_q.size()), 72'(0));
        out_rdy = 1'b1;
        @(negedge clk); out_rdy = 1'b0;
        @(negedge clk); out_rdy = 1'b1;
        expect_pkt("bp", 16'd10, 16'h0000);
        check("bp/rdy_drained", 72'(in_rdy), 72'(1));

        // Stalled barrier: abort with the timeout build, persist without it
        pkt("t5/cpu0", 16'd1, 16'h0055);
        repeat (120) @(negedge clk);
        check("t5/flag", 72'(barrier_timeout), 72'(TO_EN));
        check("t5/state", 72'(dut.w_trk_dbg.state), 72'(TO_EN ? IDLE : GATHER));
        pkt("t5/cpu0_again", 16'd1, TO_EN ? 16'h0055 : 16'h0000);
        pkt("t5/mac0", 16'd0, 16'h0000);
        pkt("t5/mac1", 16'd2, 16'h0000);
        pkt("t5/mac2", 16'd4, 16'h0000);
        pkt("t5/mac3", 16'd6, 16'h0002);
        check_trk("t5/done", IDLE, 1'b0, 8'h00);

        // Reset with a half-buffered packet
        @(negedge clk); out_rdy = 1'b0;
        in_wr = 1'b1; in_ctrl = 8'hff; in_data = hdr_in(16'd1);
        @(negedge clk); in_ctrl = 8'h00; in_data = BODY_W;
        @(negedge clk); in_wr = 1'b0; out_rdy = 1'b1;
        @(negedge clk); #2;
        check("rstmid/out_wr_pre", 72'(out_wr), 72'(1));
        reset = 1'b0;
        #1;
        check("rstmid/out_wr", 72'(out_wr), 72'(0));
        check("rstmid/in_rdy", 72'(in_rdy), 72'(1));
        check_trk("rstmid", IDLE, 1'b0, 8'h00);
        wait_words("rstmid/hdr", 1);
        if (got_q.size() >= 1) check("rstmid/hdr", got_q.pop_front(), exp_hdr(16'd1, 16'h0055));
        @(negedge clk); reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid/dropped", 72'(got_q.size()), 72'(0));
        check("rstmid/out_wr_idle", 72'(out_wr), 72'(0));
        // Trailing word of the interrupted packet passes untouched
        @(negedge clk); in_wr = 1'b1; in_ctrl = 8'h80; in_data = LAST_W;
        @(negedge clk); in_wr = 1'b0;
        wait_words("rstmid/tail", 1);
        if (got_q.size() >= 1) check("rstmid/tail", got_q.pop_front(), {8'h80, LAST_W});
        pkt("t6/cpu0", 16'd1, 16'h0055);
        pkt("t6/mac0", 16'd0, 16'h0000);
        pkt("t6/mac1", 16'd2, 16'h0000);
        pkt("t6/mac2", 16'd4, 16'h0000);
        pkt("t6/mac3", 16'd6, 16'h0002);

        repeat (5) @(negedge clk);
        check("end/no_extra", 72'(got_q.size()), 72'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
